vend_sequencer: RTL and testbench
=================================

VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 SHALL have parameter PRICE0, 5: price of slot 0 in rupees (1..15).
REQ-002 SHALL have parameters PRICE1, PRICE2, PRICE3, defaults 6, 7, 9: prices of slots 1..3 in rupees (1..15).
REQ-003 SHALL have parameter STOCK_INIT, 7: per-slot stock loaded at reset (0..7).
REQ-004 SHALL have parameter MOTOR_TIMEOUT, 255: maximum cycles to wait for motor_done (1..255).
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have ports coin_1 and coin_2, input, 1 each: one-cycle pulses, one ₹1 or ₹2 coin inserted.
REQ-008 SHALL have ports sel_valid (input, 1) and sel (input, 2): one-cycle product-selection request and slot index.
REQ-009 SHALL have port cancel, input, 1: one-cycle refund request.
REQ-010 SHALL have ports motor_req (output, 1), motor_slot (output, 2) and motor_done (input, 1): dispense handshake.
REQ-011 SHALL have port change_pulse, output, 1: each high cycle returns one ₹1 coin.
REQ-012 SHALL have port credit, output, 4: current credit, or remaining change while paying out.
REQ-013 SHALL have output pulse ports coin_reject, err_sel and fault, 1 each, plus level outputs busy (1) and sold_out (4, bit n means slot n has zero stock).

Function
REQ-014 SHALL implement states IDLE, VEND and CHANGE; busy SHALL be 1 in every state except IDLE.
REQ-015 In IDLE, a coin SHALL add its value to credit (coin_1 and coin_2 together add 3), visible on credit the next cycle.
REQ-016 A coin that would raise credit above 15 SHALL leave credit unchanged and pulse coin_reject for 1 cycle.
REQ-017 Coins arriving in VEND or CHANGE SHALL be rejected the same way (credit unchanged, coin_reject pulse).
REQ-018 In IDLE, sel_valid SHALL be compared against the registered credit; it is accepted when credit >= PRICE[sel] and the slot's stock > 0.
REQ-019 On acceptance: credit becomes credit - PRICE[sel] plus any same-cycle coin (subject to REQ-016), stock[sel] decrements, and the next state is VEND.
REQ-020 On refusal (low credit or sold out), err_sel SHALL pulse for 1 cycle, the state SHALL stay IDLE, and credit SHALL change only by same-cycle coins.
REQ-021 cancel in IDLE with credit > 0 SHALL enter CHANGE; cancel with credit 0 SHALL be ignored; cancel SHALL win over a simultaneous sel_valid (no vend, no err_sel).
REQ-022 In VEND, motor_req SHALL be 1 and motor_slot SHALL hold the selected slot, stable from the first VEND cycle until exit.
REQ-023 motor_done sampled high in VEND SHALL leave VEND: go to CHANGE if credit > 0, otherwise IDLE; motor_req SHALL be 0 the following cycle.
REQ-024 motor_done outside VEND SHALL be ignored.
REQ-025 If motor_done has not arrived after MOTOR_TIMEOUT VEND cycles: fault SHALL pulse, credit SHALL be restored by adding PRICE back, that slot's stock SHALL be forced to 0, and the state SHALL go to CHANGE if credit > 0.
REQ-026 In CHANGE, change_pulse SHALL be 1 on consecutive cycles and credit SHALL decrement by 1 per pulse; the cycle that drives credit to 0 SHALL be the last pulse, followed by IDLE.
REQ-027 sel_valid and cancel outside IDLE SHALL be ignored, with no err_sel pulse.
REQ-028 sold_out[n] SHALL be combinational from stock[n] == 0; stock SHALL never go below 0 and never be replenished except by reset.

Reset
REQ-029 With reset high at a clock edge: state goes to IDLE; credit, motor_req, motor_slot, change_pulse, coin_reject, err_sel, fault and busy all become 0; every stock becomes STOCK_INIT.
REQ-030 Reset SHALL override all other inputs, including in the middle of VEND or CHANGE; remaining change is discarded and no further pulses are issued.

Verification
REQ-031 Coins 1, 2, 2 (credit 5), then sel 0 -> motor_req=1 with motor_slot=0 next cycle; motor_done 3 cycles later -> IDLE, no change_pulse, credit 0, stock0=6.
REQ-032 Coins 2, 2, 2 (credit 6), then sel 0 -> vend, then exactly 1 change_pulse, credit 0, IDLE.
REQ-033 Credit 4, sel 0 -> err_sel for 1 cycle, credit stays 4; then cancel -> 4 consecutive change_pulses, credit counts 3, 2, 1, 0.
REQ-034 Credit 14, coin_2 -> coin_reject, credit 14; then coin_1 -> credit 15; then coin_1 and sel 3 in the same cycle -> vend accepted, credit 7 (15 - 9 + 1).
REQ-035 Credit 9, sel 1, motor_done held low -> after 255 VEND cycles fault pulse, sold_out[1]=1, 9 change_pulses; a later sel 1 -> err_sel.
REQ-036 Reset asserted during the 2nd of 5 change_pulses -> credit 0, IDLE, no further change_pulse, all stocks back to 7.

Source files
------------

// File: rtl/vend_sequencer_if.sv
// Signal bundle between the vending sequencer and its coin, selection and motor front end.
interface vend_sequencer_if;
  logic       coin_1;
  logic       coin_2;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       motor_req;
  logic [1:0] motor_slot;
  logic       motor_done;
  logic       change_pulse;
  logic [3:0] credit;
  logic       coin_reject;
  logic       err_sel;
  logic       fault;
  logic       busy;
  logic [3:0] sold_out;

  modport master (
    output coin_1, coin_2, sel_valid, sel, cancel, motor_done,
    input  motor_req, motor_slot, change_pulse, credit,
    input  coin_reject, err_sel, fault, busy, sold_out
  );

  modport slave (
    input  coin_1, coin_2, sel_valid, sel, cancel, motor_done,
    output motor_req, motor_slot, change_pulse, credit,
    output coin_reject, err_sel, fault, busy, sold_out
  );
endinterface

// File: rtl/vend_sequencer.sv
// Four-slot vending controller: credit accumulation, dispense handshake with timeout, change payout.
// state  | meaning
// IDLE   | accept coins, selections and cancel
// VEND   | motor_req high for slot_q, waiting for motor_done or timeout
// CHANGE | one change_pulse per cycle until credit reaches 0
module vend_sequencer #(
  parameter int PRICE0        = 5,
  parameter int PRICE1        = 6,
  parameter int PRICE2        = 7,
  parameter int PRICE3        = 9,
  parameter int STOCK_INIT    = 7,
  parameter int MOTOR_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  vend_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_e;

  state_e     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic [2:0] stock_q [4];
  logic [2:0] stock_d [4];
  logic [1:0] slot_q, slot_d;
  logic [7:0] timer_q, timer_d;
  logic       coin_reject_q, coin_reject_d;
  logic       err_sel_q, err_sel_d;
  logic       fault_q, fault_d;

  logic       coin_any;
  logic [4:0] coin_val;
  logic [4:0] coin_sum;
  logic [3:0] sel_price;
  logic [3:0] slot_price;
  logic [3:0] base_credit;
  logic       go_change;
  logic       accept;

  function automatic logic [3:0] price_of(input logic [1:0] s);
    case (s)
      2'd0:    price_of = 4'(PRICE0);
      2'd1:    price_of = 4'(PRICE1);
      2'd2:    price_of = 4'(PRICE2);
      default: price_of = 4'(PRICE3);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      credit_q      <= 4'd0;
      slot_q        <= 2'd0;
      timer_q       <= 8'd0;
      coin_reject_q <= 1'b0;
      err_sel_q     <= 1'b0;
      fault_q       <= 1'b0;
      for (int i = 0; i < 4; i++) stock_q[i] <= 3'(STOCK_INIT);
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      slot_q        <= slot_d;
      timer_q       <= timer_d;
      coin_reject_q <= coin_reject_d;
      err_sel_q     <= err_sel_d;
      fault_q       <= fault_d;
      for (int i = 0; i < 4; i++) stock_q[i] <= stock_d[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    slot_d        = slot_q;
    timer_d       = timer_q;
    coin_reject_d = 1'b0;
    err_sel_d     = 1'b0;
    fault_d       = 1'b0;
    for (int i = 0; i < 4; i++) stock_d[i] = stock_q[i];

    coin_any    = bus.coin_1 | bus.coin_2;
    coin_val    = 5'(bus.coin_1) + (bus.coin_2 ? 5'd2 : 5'd0);
    sel_price   = price_of(bus.sel);
    slot_price  = price_of(slot_q);
    go_change   = 1'b0;
    accept      = 1'b0;
    base_credit = credit_q;
    coin_sum    = 5'd0;

    case (state_q)
      IDLE: begin
        // cancel with zero credit has no effect, so the selection is still evaluated
        go_change = bus.cancel && (credit_q != 4'd0);
        if (!go_change && bus.sel_valid) begin
          if (credit_q >= sel_price && stock_q[bus.sel] != 3'd0) accept = 1'b1;
          else                                                    err_sel_d = 1'b1;
        end
        base_credit = accept ? (credit_q - sel_price) : credit_q;
        coin_sum    = {1'b0, base_credit} + coin_val;
        credit_d    = base_credit;
        if (coin_any) begin
          if (coin_sum > 5'd15) coin_reject_d = 1'b1;
          else                  credit_d      = coin_sum[3:0];
        end
        if (accept) begin
          stock_d[bus.sel] = stock_q[bus.sel] - 3'd1;
          slot_d           = bus.sel;
          timer_d          = 8'(MOTOR_TIMEOUT - 1);
          state_d          = VEND;
        end else if (go_change) begin
          state_d = CHANGE;
        end
      end
      VEND: begin
        coin_reject_d = coin_any;
        if (bus.motor_done) begin
          state_d = (credit_q != 4'd0) ? CHANGE : IDLE;
        end else if (timer_q == 8'd0) begin
          fault_d         = 1'b1;
          credit_d        = credit_q + slot_price;
          stock_d[slot_q] = 3'd0;
          state_d         = ((credit_q + slot_price) != 4'd0) ? CHANGE : IDLE;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_any;
        if (credit_q != 4'd0) credit_d = credit_q - 4'd1;
        if (credit_q <= 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.motor_req    = (state_q == VEND);
  assign bus.motor_slot   = slot_q;
  assign bus.change_pulse = (state_q == CHANGE) && (credit_q != 4'd0);
  assign bus.credit       = credit_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.err_sel      = err_sel_q;
  assign bus.fault        = fault_q;
  assign bus.busy         = (state_q != IDLE);

  always_comb begin
    for (int i = 0; i < 4; i++) bus.sold_out[i] = (stock_q[i] == 3'd0);
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed vector table, corner sequences, random run against a model.
module tb_vend_sequencer;

  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic reset;
  vend_sequencer_if bus ();

  vend_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state (value of the design after the most recent edge)
  int m_credit;
  int m_stock [4];
  int m_mode;      // 0 waiting, 1 dispensing, 2 paying change
  int m_slot;
  int m_cnt;
  int m_rej, m_err, m_flt;

  typedef struct {
    int c1, c2, sv, sel, can, md;
    int cr, mr, ch, rj, er, bz;
  } vec_t;

  vec_t tbl [32];

  function automatic int price(input int s);
    case (s)
      0: return 5;
      1: return 6;
      2: return 7;
      default: return 9;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_mode = 0; m_slot = 0; m_cnt = 0;
    m_rej = 0; m_err = 0; m_flt = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 7;
  endtask

  task automatic model_step(input bit rst, c1, c2, sv, input int s, input bit can, md);
    int coin, base;
    bit vend, go_pay;
    if (rst) begin
      model_reset();
      return;
    end
    coin = int'(c1) + 2 * int'(c2);
    m_rej = 0; m_err = 0; m_flt = 0;
    case (m_mode)
      0: begin
        go_pay = can && (m_credit > 0);
        vend   = 0;
        if (!go_pay && sv) begin
          if (m_credit >= price(s) && m_stock[s] > 0) vend = 1;
          else m_err = 1;
        end
        base = vend ? m_credit - price(s) : m_credit;
        if (coin > 0) begin
          if (base + coin > 15) m_rej = 1;
          else base = base + coin;
        end
        m_credit = base;
        if (vend) begin
          m_stock[s] = m_stock[s] - 1;
          m_slot = s; m_cnt = 0; m_mode = 1;
        end else if (go_pay) m_mode = 2;
      end
      1: begin
        m_rej = (coin > 0);
        m_cnt++;
        if (md) m_mode = (m_credit > 0) ? 2 : 0;
        else if (m_cnt >= TIMEOUT) begin
          m_flt = 1;
          m_credit = m_credit + price(m_slot);
          m_stock[m_slot] = 0;
          m_mode = (m_credit > 0) ? 2 : 0;
        end
      end
      default: begin
        m_rej = (coin > 0);
        m_credit = m_credit - 1;
        if (m_credit == 0) m_mode = 0;
      end
    endcase
  endtask

  function automatic int model_pack();
    int so = 0;
    for (int i = 0; i < 4; i++) if (m_stock[i] == 0) so |= (1 << i);
    return (m_credit << 12) | ((m_mode == 1) << 11) | (((m_mode == 1) ? m_slot : 0) << 9)
         | ((m_mode == 2 && m_credit > 0) << 8) | ((m_mode != 0) << 7)
         | (m_rej << 6) | (m_err << 5) | (m_flt << 4) | so;
  endfunction

  function automatic int dut_pack();
    return (int'(bus.credit) << 12) | (int'(bus.motor_req) << 11)
         | ((bus.motor_req ? int'(bus.motor_slot) : 0) << 9)
         | (int'(bus.change_pulse) << 8) | (int'(bus.busy) << 7)
         | (int'(bus.coin_reject) << 6) | (int'(bus.err_sel) << 5)
         | (int'(bus.fault) << 4) | int'(bus.sold_out);
  endfunction

  task automatic step(input bit rst, c1, c2, sv, input int s, input bit can, md);
    reset         = rst;
    bus.coin_1    = c1;
    bus.coin_2    = c2;
    bus.sel_valid = sv;
    bus.sel       = 2'(s);
    bus.cancel    = can;
    bus.motor_done = md;
    model_step(rst, c1, c2, sv, s, can, md);
    @(posedge clk);
    #1;
    chk("model", dut_pack(), model_pack());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic coin(input bit c1, c2);
    step(0, c1, c2, 0, 0, 0, 0);
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = tbl[i];
    step(0, v.c1[0], v.c2[0], v.sv[0], v.sel, v.can[0], v.md[0]);
    chk($sformatf("vec%0d", i),
        (int'(bus.credit) << 5) | (int'(bus.motor_req) << 4) | (int'(bus.change_pulse) << 3)
        | (int'(bus.coin_reject) << 2) | (int'(bus.err_sel) << 1) | int'(bus.busy),
        (v.cr << 5) | (v.mr << 4) | (v.ch << 3) | (v.rj << 2) | (v.er << 1) | v.bz);
  endtask

  initial begin
    int pulses, mcyc;
    bit got_fault;

    // c1 c2 sv sel can md | credit mreq chg rej err busy
    tbl[0]  = '{1,0,0,0,0,0,  1,0,0,0,0,0};
    tbl[1]  = '{0,1,0,0,0,0,  3,0,0,0,0,0};
    tbl[2]  = '{0,1,0,0,0,0,  5,0,0,0,0,0};
    tbl[3]  = '{0,0,1,0,0,0,  0,1,0,0,0,1};
    tbl[4]  = '{0,0,0,0,0,0,  0,1,0,0,0,1};
    tbl[5]  = '{0,0,0,0,0,0,  0,1,0,0,0,1};
    tbl[6]  = '{0,0,0,0,0,1,  0,0,0,0,0,0};
    tbl[7]  = '{0,1,0,0,0,0,  2,0,0,0,0,0};
    tbl[8]  = '{0,1,0,0,0,0,  4,0,0,0,0,0};
    tbl[9]  = '{0,1,0,0,0,0,  6,0,0,0,0,0};
    tbl[10] = '{0,0,1,0,0,0,  1,1,0,0,0,1};
    tbl[11] = '{0,0,0,0,0,1,  1,0,1,0,0,1};
    tbl[12] = '{0,0,0,0,0,0,  0,0,0,0,0,0};
    tbl[13] = '{0,1,0,0,0,0,  2,0,0,0,0,0};
    tbl[14] = '{0,1,0,0,0,0,  4,0,0,0,0,0};
    tbl[15] = '{0,0,1,0,0,0,  4,0,0,0,1,0};
    tbl[16] = '{0,0,0,0,1,0,  4,0,1,0,0,1};
    tbl[17] = '{0,0,0,0,0,0,  3,0,1,0,0,1};
    tbl[18] = '{0,0,0,0,0,0,  2,0,1,0,0,1};
    tbl[19] = '{0,0,0,0,0,0,  1,0,1,0,0,1};
    tbl[20] = '{0,0,0,0,0,0,  0,0,0,0,0,0};
    for (int i = 0; i < 7; i++) tbl[21 + i] = '{0,1,0,0,0,0, 2 * (i + 1),0,0,0,0,0};
    tbl[28] = '{0,1,0,0,0,0, 14,0,0,1,0,0};
    tbl[29] = '{1,0,0,0,0,0, 15,0,0,0,0,0};
    tbl[30] = '{1,0,1,3,0,0,  7,1,0,0,0,1};
    tbl[31] = '{0,0,0,0,0,1,  7,0,1,0,0,1};

    model_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_credit", int'(bus.credit), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_sold_out", int'(bus.sold_out), 0);

    for (int i = 0; i < 7; i++) apply_vec(i);
    chk("stock0_after_vend", int'(dut.stock_q[0]), 6);
    for (int i = 7; i < 32; i++) apply_vec(i);
    pulses = int'(bus.change_pulse);
    for (int i = 0; i < 40 && bus.busy; i++) begin
      idle();
      pulses += int'(bus.change_pulse);
    end
    chk("change_after_slot3", pulses, 7);
    chk("idle_after_change", int'(bus.busy), 0);

    // motor timeout on slot 1 with credit 9
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (4) coin(0, 1);
    coin(1, 0);
    chk("credit9", int'(bus.credit), 9);
    step(0, 0, 0, 1, 1, 0, 0);
    mcyc = int'(bus.motor_req);
    chk("motor_slot1", int'(bus.motor_slot), 1);
    got_fault = 0;
    for (int i = 0; i < 400 && !got_fault; i++) begin
      idle();
      if (bus.fault) got_fault = 1;
      else mcyc += int'(bus.motor_req);
    end
    chk("timeout_fault", int'(got_fault), 1);
    chk("vend_cycles", mcyc, 255);
    chk("sold_out1", int'(bus.sold_out[1]), 1);
    pulses = int'(bus.change_pulse);
    for (int i = 0; i < 40 && bus.busy; i++) begin
      idle();
      pulses += int'(bus.change_pulse);
    end
    chk("timeout_refund_pulses", pulses, 9);
    repeat (4) coin(0, 1);
    step(0, 0, 0, 1, 1, 0, 0);
    chk("soldout_err_sel", int'(bus.err_sel), 1);
    chk("soldout_credit", int'(bus.credit), 8);

    // reset in the middle of change payout
    step(1, 0, 0, 0, 0, 0, 0);
    coin(0, 1); coin(0, 1); coin(1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle();
    chk("second_pulse", int'(bus.change_pulse), 1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("midreset_credit", int'(bus.credit), 0);
    chk("midreset_busy", int'(bus.busy), 0);
    pulses = 0;
    repeat (5) begin
      idle();
      pulses += int'(bus.change_pulse);
    end
    chk("no_pulse_after_reset", pulses, 0);
    chk("stocks_restored", int'(dut.stock_q[0]) + int'(dut.stock_q[1]) + int'(dut.stock_q[3]), 21);

    // cancel beats a simultaneous selection
    coin(0, 1); coin(0, 1); coin(0, 1);
    step(0, 0, 0, 1, 0, 1, 0);
    chk("cancel_wins_err", int'(bus.err_sel), 0);
    chk("cancel_wins_mreq", int'(bus.motor_req), 0);

    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), $urandom_range(0, 11) == 0,
           $urandom_range(0, 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
